t3_affine_pipe: RTL and testbench

- Clocked, phase-selectable successor to the tap-3 MCM block for 1/16-precision affine interpolation.
- Accepts one sample per cycle plus a 4-bit fractional phase. Returns the sample multiplied by that phase's tap-3 coefficient, using a shared shift-add network.
- Two-stage pipeline with valid/ready handshake; sits between the reference-sample fetch and the tap summation adder.

---
 rtl/t3_affine_pipe.sv | 181 ++++++++++++++++++
 tb/tb_t3_affine_pipe.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/t3_affine_pipe.sv
// ---------------------------------------------------------------------------
// t3_affine_pipe
// Phase-selectable tap-3 multiplier for 1/16-precision affine interpolation.
// Multiplies a signed sample by the tap-3 coefficient for its fractional
// phase. Only shifts and adds are used. The design is a two-stage
// valid/ready pipeline:
//   stage 1 : registers the sample, the phase and the shared shift-add terms
//   stage 2 : applies the per-phase select/shift (and optional rounding)
//
// Parameters
//   IN_SIZE  signed input sample width (>= 4)
//   NORM     0 = raw product, 1 = (product + 32) >>> 6
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input beat present
//   in_ready   out  input beat can be accepted this cycle
//   in_x       in   signed sample, IN_SIZE bits
//   in_phase   in   fractional phase 0..15
//   out_valid  out  output beat present
//   out_ready  in   downstream accepts output beat
//   out_y      out  signed product, IN_SIZE+6 bits
//   out_phase  out  phase that accompanied out_y
// ---------------------------------------------------------------------------
module t3_affine_pipe #(
  parameter int IN_SIZE = 8,
  parameter int NORM    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_SIZE-1:0]   in_x,
  input  logic [3:0]           in_phase,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IN_SIZE+5:0]   out_y,
  output logic [3:0]           out_phase
);

  localparam int OUT_SIZE = IN_SIZE + 6;

  // Handshake
  logic w_s2_en;
  logic w_in_ready;

  // Stage-1 shared terms (combinational, from in_x)
  logic signed [OUT_SIZE-1:0] w_x1, w_x4, w_x5, w_x8, w_x13, w_x15, w_x16;
  logic signed [OUT_SIZE-1:0] w_x17, w_x29, w_x31, w_x32, w_x63;

  // Stage-1 registers
  logic                       r_s1_valid;
  logic [3:0]                 r_s1_phase;
  logic signed [OUT_SIZE-1:0] r_x1, r_x5, r_x8, r_x13, r_x15, r_x16;
  logic signed [OUT_SIZE-1:0] r_x17, r_x29, r_x31, r_x32, r_x63;

  // Stage-2 select and result
  logic signed [OUT_SIZE-1:0] w_prod;
  logic signed [OUT_SIZE-1:0] w_res;

  // Stage-2 registers
  logic                       r_out_valid;
  logic [OUT_SIZE-1:0]        r_out_y;
  logic [3:0]                 r_out_phase;

  // -------------------------------------------------------------------------
  // Handshake: stage 2 moves when empty or draining; stage 1 moves when
  // empty or when stage 2 moves, so in_ready falls only with both stages
  // full and out_ready low.
  // -------------------------------------------------------------------------
  assign w_s2_en    = !r_out_valid || out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_en;
  assign in_ready   = w_in_ready;

  // -------------------------------------------------------------------------
  // Stage 1: shared shift-add terms, all sign-extended to OUT_SIZE
  // -------------------------------------------------------------------------
  assign w_x1  = {{6{in_x[IN_SIZE-1]}}, in_x};
  assign w_x4  = w_x1 <<< 2;
  assign w_x5  = w_x4 + w_x1;
  assign w_x8  = w_x1 <<< 3;
  assign w_x13 = w_x8 + w_x5;
  assign w_x16 = w_x1 <<< 4;
  assign w_x15 = w_x16 - w_x1;
  assign w_x17 = w_x16 + w_x1;
  assign w_x29 = w_x16 + w_x13;
  assign w_x32 = w_x1 <<< 5;
  assign w_x31 = w_x32 - w_x1;
  assign w_x63 = (w_x1 <<< 6) - w_x1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_phase <= '0;
      r_x1       <= '0;
      r_x5       <= '0;
      r_x8       <= '0;
      r_x13      <= '0;
      r_x15      <= '0;
      r_x16      <= '0;
      r_x17      <= '0;
      r_x29      <= '0;
      r_x31      <= '0;
      r_x32      <= '0;
      r_x63      <= '0;
    end else begin
      if (w_in_ready) begin
        r_s1_valid <= in_valid;
      end
      // Data is captured only on an actual transfer.
      if (in_valid && w_in_ready) begin
        r_s1_phase <= in_phase;
        r_x1       <= w_x1;
        r_x5       <= w_x5;
        r_x8       <= w_x8;
        r_x13      <= w_x13;
        r_x15      <= w_x15;
        r_x16      <= w_x16;
        r_x17      <= w_x17;
        r_x29      <= w_x29;
        r_x31      <= w_x31;
        r_x32      <= w_x32;
        r_x63      <= w_x63;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: per-phase select/shift of the shared terms
  // -------------------------------------------------------------------------
  always_comb begin
    w_prod = '0;
    unique case (r_s1_phase)
      4'd0:  w_prod = '0;                  //  0
      4'd1:  w_prod = r_x1 <<< 2;          //  4
      4'd2:  w_prod = r_x8;                //  8
      4'd3:  w_prod = r_x13;               // 13
      4'd4:  w_prod = r_x17;               // 17
      4'd5:  w_prod = r_x13 <<< 1;         // 26
      4'd6:  w_prod = r_x31;               // 31
      4'd7:  w_prod = r_x17 <<< 1;         // 34
      4'd8:  w_prod = r_x5 <<< 3;          // 40
      4'd9:  w_prod = r_x29 + r_x16;       // 45
      4'd10: w_prod = r_x15 + r_x32;       // 47
      4'd11: w_prod = r_x13 <<< 2;         // 52
      4'd12: w_prod = r_x29 <<< 1;         // 58
      4'd13: w_prod = r_x15 <<< 2;         // 60
      4'd14: w_prod = r_x31 <<< 1;         // 62
      4'd15: w_prod = r_x63;               // 63
      default: w_prod = '0;
    endcase
  end

  // |product| + 32 stays below 2^(OUT_SIZE-1), so rounding cannot overflow.
  always_comb begin
    w_res = w_prod;
    if (NORM != 0) begin
      w_res = (w_prod + OUT_SIZE'(32)) >>> 6;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_y     <= '0;
      r_out_phase <= '0;
    end else if (w_s2_en) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_y     <= w_res;
        r_out_phase <= r_s1_phase;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_y     = r_out_y;
  assign out_phase = r_out_phase;

endmodule

// File: tb/tb_t3_affine_pipe.sv
// ---------------------------------------------------------------------------
// tb_t3_affine_pipe
// Three instances share one handshake stream:
//   a : IN_SIZE=8,  NORM=0
//   b : IN_SIZE=8,  NORM=1
//   c : IN_SIZE=12, NORM=0
// The driver pushes expected results into a scoreboard queue on every
// accepted beat; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_t3_affine_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_phase = '0;
  logic        out_ready = 1'b1;
  logic [7:0]  in_x8 = '0;
  logic [11:0] in_x12 = '0;

  logic        in_ready_a, in_ready_b, in_ready_c;
  logic        out_valid_a, out_valid_b, out_valid_c;
  logic [13:0] out_y_a, out_y_b;
  logic [17:0] out_y_c;
  logic [3:0]  out_phase_a, out_phase_b, out_phase_c;

  t3_affine_pipe #(.IN_SIZE(8), .NORM(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_x(in_x8), .in_phase(in_phase), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_y(out_y_a), .out_phase(out_phase_a));

  t3_affine_pipe #(.IN_SIZE(8), .NORM(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_x(in_x8), .in_phase(in_phase), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_y(out_y_b), .out_phase(out_phase_b));

  t3_affine_pipe #(.IN_SIZE(12), .NORM(0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
    .in_x(in_x12), .in_phase(in_phase), .out_valid(out_valid_c),
    .out_ready(out_ready), .out_y(out_y_c), .out_phase(out_phase_c));

  always #5 clk = ~clk;

  typedef struct {
    int       ya;
    int       yb;
    int       yc;
    logic [3:0] ph;
    int       acc;
  } exp_t;

  exp_t q[$];
  int   coef[16] = '{0, 4, 8, 13, 17, 26, 31, 34, 40, 45, 47, 52, 58, 60, 62, 63};
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   rdy_mode = 0;
  int   n_ir_low = 0;

  function automatic int norm6(input int p);
    return (p + 32) >>> 6;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Random backpressure when rdy_mode==1
  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor / scoreboard checker
  initial begin
    bit   stalled_prev;
    int   pya, pyb, pyc;
    int   ppa;
    bit   ev;
    exp_t h;
    stalled_prev = 1'b0;
    pya = 0; pyb = 0; pyc = 0; ppa = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled_prev = 1'b0;
      end else begin
        // With the queue holding the beats in flight, in_ready must only
        // drop when two are held and the output is stalled.
        ev = !(q.size() == 2 && !out_ready);
        chk("in_ready_a", int'(in_ready_a), int'(ev));
        chk("in_ready_b", int'(in_ready_b), int'(ev));
        chk("in_ready_c", int'(in_ready_c), int'(ev));
        if (!in_ready_a) n_ir_low++;

        if (stalled_prev) begin
          chk("hold_y_a", int'($signed(out_y_a)), pya);
          chk("hold_y_b", int'($signed(out_y_b)), pyb);
          chk("hold_y_c", int'($signed(out_y_c)), pyc);
          chk("hold_phase_a", int'(out_phase_a), ppa);
        end

        // Head beat is visible exactly two cycles after it was presented
        // and accepted, or as soon as the beat ahead of it has drained.
        ev = (q.size() > 0) && (cyc >= q[0].acc + 2);
        chk("out_valid_a", int'(out_valid_a), int'(ev));
        chk("out_valid_b", int'(out_valid_b), int'(ev));
        chk("out_valid_c", int'(out_valid_c), int'(ev));

        if (ev && out_valid_a) begin
          h = q[0];
          chk("out_y_a", int'($signed(out_y_a)), h.ya);
          chk("out_y_b", int'($signed(out_y_b)), h.yb);
          chk("out_y_c", int'($signed(out_y_c)), h.yc);
          chk("out_phase_a", int'(out_phase_a), int'(h.ph));
          chk("out_phase_c", int'(out_phase_c), int'(h.ph));
          if (out_ready) void'(q.pop_front());
        end

        stalled_prev = out_valid_a && !out_ready;
        pya = int'($signed(out_y_a));
        pyb = int'($signed(out_y_b));
        pyc = int'($signed(out_y_c));
        ppa = int'(out_phase_a);
      end
    end
  end

  // Present one beat starting at posedge+1; returns at posedge+1 after the
  // transfer edge.
  task automatic send(input int a, input int c, input int p);
    int   n;
    bit   done;
    exp_t e;
    n = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_x8    = 8'(a);
    in_x12   = 12'(c);
    in_phase = 4'(p);
    while (!done) begin
      @(negedge clk);
      #1;
      if (in_ready_a) begin
        e.ya  = a * coef[p];
        e.yb  = norm6(a * coef[p]);
        e.yc  = c * coef[p];
        e.ph  = 4'(p);
        e.acc = cyc;
        q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 200) begin
        chk("send_timeout", 0, 1);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    in_x8    = 8'($urandom);
    in_x12   = 12'($urandom);
    in_phase = 4'($urandom);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid_a), 0);
    chk("rst_out_y", int'(out_y_a), 0);
    chk("rst_in_ready", int'(in_ready_a), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Exhaustive phases, x=10, back-to-back
    out_ready = 1'b1;
    for (int p = 0; p < 16; p++) send(10, 10, p);
    drain("drain_phases");

    // Extremes and NORM / wide-instance directed values
    send(-128, -2048, 15);
    send(127, 2047, 13);
    send(127, 2047, 15);
    send(-1, -1, 1);
    send(77, -999, 0);
    send(100, 100, 8);
    send(-100, -100, 8);
    drain("drain_extremes");

    // Backpressure: x=1..6 phase 8, output stalled for four cycles
    n_ir_low = 0;
    fork
      begin
        for (int i = 1; i <= 6; i++) send(i, i, 8);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");
    chk("bp_in_ready_dropped", int'(n_ir_low > 0), 1);

    // Reset mid-stream with two beats in flight
    out_ready = 1'b0;
    send(5, 5, 2);
    send(6, 6, 3);
    chk("pre_reset_in_flight", q.size(), 2);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_out_valid_a", int'(out_valid_a), 0);
    chk("mid_rst_out_valid_c", int'(out_valid_c), 0);
    chk("mid_rst_out_y_a", int'(out_y_a), 0);
    chk("mid_rst_out_y_c", int'(out_y_c), 0);
    chk("mid_rst_out_phase", int'(out_phase_a), 0);
    chk("mid_rst_in_ready", int'(in_ready_a), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(3, 3, 4);
    drain("drain_after_reset");

    // Random sweep: every 8-bit x against every phase, random gaps and
    // random backpressure
    rdy_mode = 1;
    for (int xi = 0; xi < 256; xi++) begin
      for (int p = 0; p < 16; p++) begin
        send(xi - 128, int'($urandom_range(0, 4095)) - 2048, p);
        if ($urandom_range(0, 7) == 0) begin
          @(posedge clk);
          #1;
        end
      end
    end
    rdy_mode = 0;
    out_ready = 1'b1;
    drain("drain_sweep");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
